// File: rtl/dmem_bridge.sv
// Memory-stage bridge: turns MEM-stage load/store controls into a registered req/ack
// bus transaction, stalls the pipeline while it is outstanding, and aborts hung accesses.
module dmem_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        AdeM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bridgeState_t;

    bridgeState_t    state;
    logic [CntW-1:0] busyCnt;
    logic            acc;
    logic            ok;

    // Access qualification: only word-aligned loads/stores reach the bus.
    always_comb begin
        acc = MemReadM | MemWriteM;
        ok  = acc & (ALUResultM[1:0] == 2'b00);
    end

    // Stall and misalign flags depend on the live MEM-stage controls, so they stay combinational.
    always_comb begin
        StallM = 1'b0;
        AdeM   = 1'b0;
        if (!rst) begin
            StallM = ((state == IDLE) && ok) || (state == BUSY);
            AdeM   = (state == IDLE) && acc && !ok;
        end
    end

    // Transaction FSM with registered bus and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busyCnt   <= '0;
            ReadDataM <= '0;
            BusErrM   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            BusErrM <= 1'b0;
            case (state)
                IDLE: begin
                    if (ok) begin
                        mem_addr  <= {ALUResultM[31:2], 2'b00};
                        mem_wdata <= WriteDataM;
                        mem_we    <= MemWriteM;
                        mem_req   <= 1'b1;
                        busyCnt   <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            ReadDataM <= mem_rdata;
                        end
                        state <= DONE;
                    end else if (busyCnt == LastCnt) begin
                        // Watchdog abort: a load returns the poison word instead of hanging.
                        mem_req <= 1'b0;
                        BusErrM <= 1'b1;
                        if (!mem_we) begin
                            ReadDataM <= ERR_WORD;
                        end
                        state <= DONE;
                    end else begin
                        busyCnt <= busyCnt + CntW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: a default-timeout instance for normal traffic and a
// TIMEOUT=4 instance for the watchdog path.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        AdeM;
    logic        BusErrM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        toMemRead;
    logic        toAck;
    logic [31:0] toReadData;
    logic        toStall;
    logic        toAde;
    logic        toBusErr;
    logic        toReq;
    logic        toWe;
    logic [31:0] toAddr;
    logic [31:0] toWdata;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    dmem_bridge dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallM(StallM), .AdeM(AdeM), .BusErrM(BusErrM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    dmem_bridge #(.TIMEOUT(4), .ERR_WORD(32'hDEADBEEF)) dutTo (
        .clk(clk), .rst(rst),
        .MemReadM(toMemRead), .MemWriteM(1'b0),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(toReadData), .StallM(toStall), .AdeM(toAde), .BusErrM(toBusErr),
        .mem_req(toReq), .mem_we(toWe), .mem_addr(toAddr), .mem_wdata(toWdata),
        .mem_rdata(mem_rdata), .mem_ack(toAck)
    );

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h10;
        WriteDataM = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0; toMemRead = 1'b0; toAck = 1'b0;
        nextCycle(); nextCycle();
        @(negedge clk);
        nChecks++;
        if (StallM !== 1'b0) begin nFails++; $display("FAIL reset_stall: got %b want 0", StallM); end
        nChecks++;
        if ({mem_req, mem_we, BusErrM} !== 3'b000) begin
            nFails++; $display("FAIL reset_ctl: got req/we/err %b want 000", {mem_req, mem_we, BusErrM});
        end
        nChecks++;
        if ({ReadDataM, mem_addr, mem_wdata} !== 96'h0) begin
            nFails++; $display("FAIL reset_data: got rd=%h addr=%h wd=%h want all 0", ReadDataM, mem_addr, mem_wdata);
        end
        nextCycle();
        ALUResultM = 32'h13;
        @(negedge clk);
        nChecks++;
        if (AdeM !== 1'b0) begin nFails++; $display("FAIL reset_ade: got %b want 0", AdeM); end
        nextCycle();
        rst = 1'b0; MemReadM = 1'b0; ALUResultM = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nChecks++;
            if ({StallM, mem_req} !== 2'b00) begin
                nFails++; $display("FAIL idle_quiet[%0d]: got stall/req %b want 00", i, {StallM, mem_req});
            end
            nextCycle();
        end
    endtask

    task automatic test_load();
        int stallCnt = 0;
        MemReadM = 1'b1; ALUResultM = 32'h0000_0010;
        @(negedge clk);
        if (StallM) stallCnt++;
        nChecks++;
        if (mem_req !== 1'b0) begin nFails++; $display("FAIL load_req_early: got %b want 0", mem_req); end
        nextCycle();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        if (StallM) stallCnt++;
        nChecks++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
            nFails++; $display("FAIL load_bus: got req=%b we=%b addr=%h want 1 0 00000010", mem_req, mem_we, mem_addr);
        end
        nextCycle();
        mem_ack = 1'b0; mem_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        if (StallM) stallCnt++;
        nChecks++;
        if (ReadDataM !== 32'h1234_5678) begin nFails++; $display("FAIL load_data: got %h want 12345678", ReadDataM); end
        nChecks++;
        if (mem_req !== 1'b0) begin nFails++; $display("FAIL load_req_drop: got %b want 0", mem_req); end
        nChecks++;
        if (stallCnt != 2) begin nFails++; $display("FAIL load_stall_cycles: got %0d want 2", stallCnt); end
        nextCycle();
        MemReadM = 1'b0;
    endtask

    task automatic test_store_delayed();
        int stallCnt = 0;
        MemWriteM = 1'b1; ALUResultM = 32'h20; WriteDataM = 32'hCAFE_F00D;
        @(negedge clk);
        if (StallM) stallCnt++;
        nChecks++;
        if ({StallM, mem_req} !== 2'b10) begin
            nFails++; $display("FAIL store_enter: got stall/req %b want 10", {StallM, mem_req});
        end
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            mem_ack = (i == 5); mem_rdata = 32'hFFFF_0000;
            @(negedge clk);
            if (StallM) stallCnt++;
            nChecks++;
            if ({mem_req, mem_we, mem_wdata, mem_addr} !== {1'b1, 1'b1, 32'hCAFE_F00D, 32'h20}) begin
                nFails++;
                $display("FAIL store_busy[%0d]: got req=%b we=%b wd=%h addr=%h want 1 1 cafef00d 00000020",
                         i, mem_req, mem_we, mem_wdata, mem_addr);
            end
        end
        nextCycle();
        mem_ack = 1'b0;
        @(negedge clk);
        if (StallM) stallCnt++;
        nChecks++;
        if (stallCnt != 7) begin nFails++; $display("FAIL store_stall_cycles: got %0d want 7", stallCnt); end
        nChecks++;
        if (ReadDataM !== 32'h1234_5678) begin nFails++; $display("FAIL store_rd_held: got %h want 12345678", ReadDataM); end
        nextCycle();
        MemWriteM = 1'b0;
    endtask

    task automatic test_misaligned();
        MemReadM = 1'b1; ALUResultM = 32'h22;
        @(negedge clk);
        nChecks++;
        if ({AdeM, StallM, mem_req} !== 3'b100) begin
            nFails++; $display("FAIL ade_load: got ade/stall/req %b want 100", {AdeM, StallM, mem_req});
        end
        nextCycle();
        MemReadM = 1'b0; MemWriteM = 1'b1; ALUResultM = 32'h23;
        @(negedge clk);
        nChecks++;
        if ({AdeM, StallM} !== 2'b10) begin nFails++; $display("FAIL ade_store: got ade/stall %b want 10", {AdeM, StallM}); end
        nextCycle();
        MemWriteM = 1'b0; ALUResultM = 32'h22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nChecks++;
            if ({AdeM, StallM, mem_req} !== 3'b000) begin
                nFails++; $display("FAIL ade_after[%0d]: got ade/stall/req %b want 000", i, {AdeM, StallM, mem_req});
            end
            nextCycle();
        end
        nChecks++;
        if (ReadDataM !== 32'h1234_5678) begin nFails++; $display("FAIL ade_rd_held: got %h want 12345678", ReadDataM); end
    endtask

    task automatic test_both_set();
        MemReadM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h30; WriteDataM = 32'h1111_2222;
        nextCycle();
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        @(negedge clk);
        nChecks++;
        if ({mem_we, mem_wdata} !== {1'b1, 32'h1111_2222}) begin
            nFails++; $display("FAIL both_store_wins: got we=%b wd=%h want 1 11112222", mem_we, mem_wdata);
        end
        nextCycle();
        mem_ack = 1'b0;
        @(negedge clk);
        nChecks++;
        if (ReadDataM !== 32'h1234_5678) begin nFails++; $display("FAIL both_rd_held: got %h want 12345678", ReadDataM); end
        nextCycle();
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    task automatic test_timeout();
        int reqCnt = 0;
        int errCnt = 0;
        toMemRead = 1'b1; ALUResultM = 32'h40;
        @(negedge clk);
        nChecks++;
        if ({toStall, toReq} !== 2'b10) begin nFails++; $display("FAIL to_enter: got stall/req %b want 10", {toStall, toReq}); end
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            @(negedge clk);
            if (toReq) reqCnt++;
            if (toBusErr) errCnt++;
        end
        nextCycle();
        @(negedge clk);
        if (toBusErr) errCnt++;
        nChecks++;
        if ({toReq, toBusErr, toStall} !== 3'b010) begin
            nFails++; $display("FAIL to_done: got req/err/stall %b want 010", {toReq, toBusErr, toStall});
        end
        nChecks++;
        if (toReadData !== 32'hDEAD_BEEF) begin nFails++; $display("FAIL to_errword: got %h want deadbeef", toReadData); end
        nChecks++;
        if (reqCnt != 4) begin nFails++; $display("FAIL to_req_cycles: got %0d want 4", reqCnt); end
        nextCycle();
        toMemRead = 1'b0;
        for (int i = 0; i < 4; i++) begin
            toAck = (i == 1); mem_rdata = 32'h5555_AAAA;
            @(negedge clk);
            if (toBusErr) errCnt++;
            nChecks++;
            if ({toReq, toStall, toReadData} !== {2'b00, 32'hDEAD_BEEF}) begin
                nFails++; $display("FAIL to_late_ack[%0d]: got req=%b stall=%b rd=%h want 0 0 deadbeef", i, toReq, toStall, toReadData);
            end
            nextCycle();
        end
        toAck = 1'b0;
        nChecks++;
        if (errCnt != 1) begin nFails++; $display("FAIL to_err_pulses: got %0d want 1", errCnt); end
    endtask

    task automatic test_reset_busy();
        int stallCnt = 0;
        MemReadM = 1'b1; ALUResultM = 32'h80;
        nextCycle();
        @(negedge clk);
        nChecks++;
        if (mem_req !== 1'b1) begin nFails++; $display("FAIL rb_busy1_req: got %b want 1", mem_req); end
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        nChecks++;
        if (StallM !== 1'b0) begin nFails++; $display("FAIL rb_stall_forced: got %b want 0", StallM); end
        nextCycle();
        rst = 1'b0; MemReadM = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({mem_req, StallM, ReadDataM} !== {2'b00, 32'h0}) begin
            nFails++; $display("FAIL rb_after: got req=%b stall=%b rd=%h want 0 0 00000000", mem_req, StallM, ReadDataM);
        end
        nextCycle();
        MemReadM = 1'b1; ALUResultM = 32'h84;
        @(negedge clk);
        if (StallM) stallCnt++;
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            mem_ack = (i == 1); mem_rdata = 32'h600D_F00D;
            @(negedge clk);
            if (StallM) stallCnt++;
            nChecks++;
            if ({mem_req, mem_addr} !== {1'b1, 32'h84}) begin
                nFails++; $display("FAIL rb_fresh_bus[%0d]: got req=%b addr=%h want 1 00000084", i, mem_req, mem_addr);
            end
        end
        nextCycle();
        mem_ack = 1'b0;
        @(negedge clk);
        if (StallM) stallCnt++;
        nChecks++;
        if (ReadDataM !== 32'h600D_F00D) begin nFails++; $display("FAIL rb_fresh_data: got %h want 600df00d", ReadDataM); end
        nChecks++;
        if (stallCnt != 3) begin nFails++; $display("FAIL rb_fresh_stall: got %0d want 3", stallCnt); end
        nextCycle();
        MemReadM = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_delayed();
        test_misaligned();
        test_both_set();
        test_timeout();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Memory-stage bridge between the pipelined CPU datapath and a variable-latency data RAM with a req/ack handshake. It turns the MEM-stage load/store controls into a registered bus transaction and returns the load word as `ReadDataM`. While a transaction is outstanding it drives `StallM` to the hazard unit, which freezes every stage from F through M. A watchdog aborts a hung transaction, and misaligned word accesses are rejected without reaching the bus.

## Interface
Parameters:
- `TIMEOUT`, 255, max BUSY cycles before abort (1..65535)
- `ERR_WORD`, 32'hDEADBEEF, value returned on a timed-out load

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `MemReadM`  in  1  MEM-stage load
- `MemWriteM`  in  1  MEM-stage store; wins if both are set
- `ALUResultM`  in  32  byte address
- `WriteDataM`  in  32  store data
- `ReadDataM`  out  32  load result, registered, held between loads
- `StallM`  out  1  pipeline freeze request
- `AdeM`  out  1  misaligned access flag (combinational, one cycle)
- `BusErrM`  out  1  timeout flag (registered, one-cycle pulse)
- `mem_req`  out  1  bus request, registered
- `mem_we`  out  1  1 = write
- `mem_addr`  out  32  word address {addr[31:2],2'b00}
- `mem_wdata`  out  32  write data
- `mem_rdata`  in  32  read data, valid when `mem_ack` is high
- `mem_ack`  in  1  completion; sampled only in BUSY

## Operation
- `acc` = `MemReadM` | `MemWriteM`. `ok` = `acc` & (`ALUResultM[1:0]` == 0).
- FSM with three states: IDLE, BUSY, DONE. The reset state is IDLE.
- IDLE:
  - `StallM` = `ok`.
  - If `ok`, register `mem_addr`, `mem_wdata` and `mem_we` = `MemWriteM`, set `mem_req`, clear the watchdog count, then go to BUSY.
  - If `acc` & !`ok`, `AdeM` = 1, no stall, no bus activity, `ReadDataM` unchanged, stay in IDLE.
- BUSY:
  - `StallM` = 1. `mem_req`, `mem_addr`, `mem_wdata` and `mem_we` are held stable.
  - On `mem_ack`: clear `mem_req`. For a load, capture `mem_rdata` into `ReadDataM`. Go to DONE.
  - Otherwise, when the count equals `TIMEOUT`-1: clear `mem_req`, pulse `BusErrM`, load `ERR_WORD` into `ReadDataM` if the access is a load, and go to DONE.
  - Otherwise the count increments (16-bit).
- DONE:
  - `StallM` = 0, so the pipeline advances on this edge and the MEM_WB register samples `ReadDataM`.
  - Always return to IDLE. A new access cannot start in DONE.
- Stores never modify `ReadDataM`.
- `mem_ack` is ignored in IDLE and DONE, including a late ack after a timeout.
- `AdeM` is gated to 0 when the state is not IDLE.
- Reset values: `ReadDataM`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `BusErrM`=0. `StallM` and `AdeM` are forced to 0 while `rst`=1.
- Reset during BUSY: `mem_req` drops at that edge and the transaction is abandoned. The memory model must accept a dropped request.

## Timing
- Access enters M in cycle t (IDLE, stalled).
- BUSY starts at t+1 with `mem_req`=1.
- With an ack in the first BUSY cycle: DONE at t+2, and the pipeline advances at the end of t+2. That is 2 stall cycles minimum.
- With the ack k cycles late: stall is 2+k cycles.
- Timeout: `BusErrM` is high during the DONE cycle, which is TIMEOUT+1 cycles after t.
- Back-to-back accesses: the second access is seen in IDLE at t+3 at the earliest. No cycle is lost beyond DONE→IDLE.
- Non-memory instructions never stall.

## Test plan
- Reset → all outputs 0. Release reset with no access → `StallM`=0 and `mem_req`=0 indefinitely.
- Load from 0x0000_0010, memory acks after 0 extra cycles with 0x1234_5678:
  - `StallM` is 1 for exactly 2 cycles.
  - `mem_addr` is 0x10 and `mem_we`=0.
  - `ReadDataM` is 0x1234_5678 in DONE and is held through a following store.
- Store 0xCAFE_F00D to 0x20 with the ack delayed 5 cycles:
  - `mem_we`=1 and `mem_wdata` is stable for all 6 BUSY cycles.
  - `StallM` is high for 7 cycles.
  - `ReadDataM` is unchanged.
- Load from 0x22 → `AdeM`=1 for one cycle, `StallM`=0, `mem_req` never rises.
- `TIMEOUT`=4, load with no ack:
  - `mem_req` drops after 4 BUSY cycles.
  - `BusErrM` pulses once and `ReadDataM`=0xDEADBEEF.
  - An ack 2 cycles later is ignored.
- Assert `rst` in the 2nd BUSY cycle → the next edge gives IDLE, `mem_req`=0, `StallM`=0. A fresh load afterwards completes normally.
